acc_ctrl_gen: RTL and testbench
===============================

ACC_CTRL_GEN -- requirements
Module: acc_ctrl_gen

Interface
REQ-001 Parameter OPC_W, 4, opcode width; values below 4 are a configuration error, and nonzero bits above bit 3 decode as illegal.
REQ-002 Parameter ALUOP_W, 4, width of alu_op.
REQ-003 clk input 1 clock; all state updates on rising edge.
REQ-004 rst input 1 reset, asynchronous, active-high.
REQ-005 opc input OPC_W opcode field of IR; valid from the S_ID cycle onward.
REQ-006 mem_ack input 1 memory handshake completion; any number of wait cycles allowed.
REQ-007 zero input 1 ACC==0 flag; neg input 1 ACC sign flag.
REQ-008 resume input 1 single-cycle pulse that leaves S_HALT.
REQ-009 Outputs, 1 bit each: mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, acc_write, acc_src, alu_src_a, alu_src_b, rst_dp, halted, illegal.
REQ-010 alu_op output ALUOP_W: 0 ADD, 1 SUB, 2 AND, 3 NOT, 4 OR, 5 XOR.

Function
REQ-011 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 NOT, 4 LDA, 5 STA, 6 JMP, 7 JZ, 8 OR, 9 XOR, A JN, B NOP, F HLT; C-E illegal.
REQ-012 States: S_RST, S_IF, S_ID, S_MEM, S_EX, S_WB, S_ST, S_HALT.
REQ-013 Outputs are decoded from state, opc, mem_ack and flags; every output not listed for a state is 0.
REQ-014 S_RST: rst_dp=1 for exactly one cycle -> S_IF.
REQ-015 S_IF: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=1.
REQ-016 S_IF: ir_write=1 and pc_write=1 only in the cycle where mem_ack=1 -> S_ID; otherwise hold in S_IF.
REQ-017 S_ID, one cycle: ADD/SUB/AND/OR/XOR/LDA -> S_MEM; NOT -> S_EX; STA -> S_ST; NOP -> S_IF.
REQ-018 S_ID JMP: pc_src=0, pc_write=1 -> S_IF.
REQ-019 S_ID JZ: pc_src=0, pc_write=zero -> S_IF; JN is identical with neg in place of zero.
REQ-020 S_ID HLT -> S_HALT; illegal opcode -> S_HALT with the illegal flag set.
REQ-021 S_MEM: mem_req=1, iord=1, held until mem_ack.
REQ-022 S_MEM on ack: mdr_write=1; LDA also gets acc_src=1, acc_write=1 -> S_IF; other opcodes -> S_EX.
REQ-023 S_EX: alu_src_a=1 (ACC), alu_src_b=0 (MDR), alu_op per opcode -> S_WB; NOT ignores operand B.
REQ-024 S_WB: acc_src=0, acc_write=1 -> S_IF.
REQ-025 S_ST: mem_req=1, mem_we=1, iord=1, held until mem_ack -> S_IF.
REQ-026 S_HALT: halted=1, all strobes 0.
REQ-027 S_HALT with resume=1 and illegal=0 -> S_IF; when illegal=1, resume is ignored.
REQ-028 illegal is a registered sticky flag, cleared only by rst.
REQ-029 Zero-wait cycle counts: ALU ops 5, NOT 4, LDA 3, STA 3, JMP/JZ/JN/NOP 2.
REQ-030 Each additional wait cycle adds exactly one cycle.
REQ-031 mem_ack outside S_IF/S_MEM/S_ST is ignored.
REQ-032 resume outside S_HALT is ignored.
REQ-033 Strobes ir_write, mdr_write, acc_write and pc_write each pulse at most once per instruction.

Reset
REQ-034 rst=1 forces S_RST and clears illegal immediately, independent of clk, including mid-handshake.
REQ-035 While rst=1, all outputs except rst_dp are 0, and rst_dp=1.
REQ-036 The first rising edge after rst deasserts leaves S_RST for S_IF.

Structure
REQ-037 Package acc_ctrl_pkg holds opcode constants, alu_op encodings and the state enumeration.
REQ-038 Sub-module acc_ctrl_decode is combinational and maps opc to a class: MEMALU, UNALU, LOAD, STORE, JUMP, BRZ, BRN, NOP, HALT, ILLEGAL.
REQ-039 State register and sticky illegal flag live only in acc_ctrl_gen.

Verification
REQ-040 Release rst, opc=0 (ADD), mem_ack tied 1 -> rst_dp for 1 cycle, then IF, ID, MEM, EX, WB; acc_write in cycle 5; alu_op=0 in EX.
REQ-041 LDA with mem_ack delayed 3 cycles in S_MEM -> mem_req/iord held 4 cycles; acc_src=acc_write=1 only in the ack cycle; total 6 cycles.
REQ-042 JZ with zero=1 -> pc_write=1, pc_src=0 in ID; JZ with zero=0 -> pc_write=0 in ID; next state S_IF in both cases.
REQ-043 opc=C -> illegal=1, halted=1; a resume pulse leaves the FSM in S_HALT; rst clears both flags.
REQ-044 HLT then resume pulse -> halted drops next cycle, S_IF follows; a STA with ack after 2 waits shows mem_we=1 for 3 cycles.
REQ-045 rst asserted during S_ST wait -> mem_we and mem_req drop without a clock edge; resumes via S_RST, S_IF.

Source files
------------

// File: rtl/acc_ctrl_pkg.sv
// acc_ctrl_pkg: opcode, alu_op and state/class encodings for the accumulator controller.
package acc_ctrl_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_NOT = 4'h3;
  localparam logic [3:0] OP_LDA = 4'h4;
  localparam logic [3:0] OP_STA = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_JN  = 4'hA;
  localparam logic [3:0] OP_NOP = 4'hB;
  localparam logic [3:0] OP_HLT = 4'hF;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_NOT = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5;
  typedef enum logic [2:0] {S_RST, S_IF, S_ID, S_MEM, S_EX, S_WB, S_ST, S_HALT} state_t;
  typedef enum logic [3:0] {
    C_MEMALU, C_UNALU, C_LOAD, C_STORE, C_JUMP, C_BRZ, C_BRN, C_NOP, C_HALT, C_ILLEGAL
  } cls_t;
endpackage

// File: rtl/acc_ctrl_decode.sv
// acc_ctrl_decode: combinational opcode classifier and ALU operation lookup.
module acc_ctrl_decode
  import acc_ctrl_pkg::*;
#(
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opc,
  output cls_t             cls,
  output logic [3:0]       alu_op
);
  logic [3:0] lo;
  logic       hi;
  if (OPC_W < 4) begin : g_cfg
    $error("acc_ctrl_decode: OPC_W must be at least 4");
  end
  assign lo = opc[3:0];
  // any set bit above the 4-bit opcode space makes the instruction illegal
  assign hi = |(opc >> 4);
  always_comb begin
    cls    = C_ILLEGAL;
    alu_op = ALU_ADD;
    if (!hi) begin
      case (lo)
        OP_ADD: cls = C_MEMALU;
        OP_SUB: begin cls = C_MEMALU; alu_op = ALU_SUB; end
        OP_AND: begin cls = C_MEMALU; alu_op = ALU_AND; end
        OP_OR:  begin cls = C_MEMALU; alu_op = ALU_OR; end
        OP_XOR: begin cls = C_MEMALU; alu_op = ALU_XOR; end
        OP_NOT: begin cls = C_UNALU; alu_op = ALU_NOT; end
        OP_LDA: cls = C_LOAD;
        OP_STA: cls = C_STORE;
        OP_JMP: cls = C_JUMP;
        OP_JZ:  cls = C_BRZ;
        OP_JN:  cls = C_BRN;
        OP_NOP: cls = C_NOP;
        OP_HLT: cls = C_HALT;
        default: cls = C_ILLEGAL;
      endcase
    end
  end
endmodule

// File: rtl/acc_ctrl_gen.sv
// acc_ctrl_gen: multi-cycle control FSM for a single-accumulator datapath.
module acc_ctrl_gen
  import acc_ctrl_pkg::*;
#(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opc,
  input  logic               mem_ack,
  input  logic               zero,
  input  logic               neg,
  input  logic               resume,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               ir_write,
  output logic               mdr_write,
  output logic               pc_write,
  output logic               pc_src,
  output logic               acc_write,
  output logic               acc_src,
  output logic               alu_src_a,
  output logic               alu_src_b,
  output logic               rst_dp,
  output logic               halted,
  output logic               illegal,
  output logic [ALUOP_W-1:0] alu_op
);
  state_t     state, nxt;
  cls_t       cls;
  logic [3:0] aop_ex, aop;
  logic       ill;
  acc_ctrl_decode #(.OPC_W(OPC_W)) u_dec (.opc(opc), .cls(cls), .alu_op(aop_ex));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RST;
      ill   <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_ID && cls == C_ILLEGAL) ill <= 1'b1;
    end
  end
  assign illegal = ill;
  assign alu_op  = ALUOP_W'(aop);
  always_comb begin
    nxt       = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    mdr_write = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 1'b0;
    acc_write = 1'b0;
    acc_src   = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    rst_dp    = 1'b0;
    halted    = 1'b0;
    aop       = ALU_ADD;
    case (state)
      S_RST: begin
        rst_dp = 1'b1;
        nxt    = S_IF;
      end
      S_IF: begin
        mem_req   = 1'b1;
        alu_src_b = 1'b1;
        pc_src    = 1'b1;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
        nxt       = mem_ack ? S_ID : S_IF;
      end
      S_ID: begin
        case (cls)
          C_MEMALU, C_LOAD: nxt = S_MEM;
          C_UNALU:          nxt = S_EX;
          C_STORE:          nxt = S_ST;
          C_JUMP:  begin pc_write = 1'b1; nxt = S_IF; end
          C_BRZ:   begin pc_write = zero; nxt = S_IF; end
          C_BRN:   begin pc_write = neg;  nxt = S_IF; end
          C_NOP:            nxt = S_IF;
          default:          nxt = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ack;
        acc_write = mem_ack && cls == C_LOAD;
        acc_src   = mem_ack && cls == C_LOAD;
        nxt       = !mem_ack ? S_MEM : cls == C_LOAD ? S_IF : S_EX;
      end
      S_EX: begin
        alu_src_a = 1'b1;
        aop       = aop_ex;
        nxt       = S_WB;
      end
      S_WB: begin
        acc_write = 1'b1;
        nxt       = S_IF;
      end
      S_ST: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        nxt     = mem_ack ? S_IF : S_ST;
      end
      S_HALT: begin
        halted = 1'b1;
        nxt    = resume && !ill ? S_IF : S_HALT;
      end
      default: nxt = S_RST;
    endcase
  end
endmodule

// File: tb/tb_acc_ctrl_gen.sv
// tb_acc_ctrl_gen: instruction-level model of the controller with per-cycle output checking.
module tb_acc_ctrl_gen;
  typedef logic [17:0] vec_t;
  localparam vec_t MREQ   = vec_t'(1) << 17;
  localparam vec_t MWE    = vec_t'(1) << 16;
  localparam vec_t IORD   = vec_t'(1) << 15;
  localparam vec_t IRW    = vec_t'(1) << 14;
  localparam vec_t MDRW   = vec_t'(1) << 13;
  localparam vec_t PCW    = vec_t'(1) << 12;
  localparam vec_t PCSRC  = vec_t'(1) << 11;
  localparam vec_t ACCW   = vec_t'(1) << 10;
  localparam vec_t ACCSRC = vec_t'(1) << 9;
  localparam vec_t SRCA   = vec_t'(1) << 8;
  localparam vec_t SRCB   = vec_t'(1) << 7;
  localparam vec_t RSTDP  = vec_t'(1) << 6;
  localparam vec_t HALTV  = vec_t'(1) << 5;
  localparam vec_t ILL    = vec_t'(1) << 4;
  logic clk = 1'b0, rst = 1'b1, mem_ack = 1'b0, zero = 1'b0, neg = 1'b0, resume = 1'b0;
  logic [3:0] opc = 4'h0, alu_op;
  logic mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, acc_write, acc_src;
  logic alu_src_a, alu_src_b, rst_dp, halted, illegal;
  vec_t got;
  vec_t exp_q[$];
  int n_chk = 0, n_fail = 0, c;
  acc_ctrl_gen dut (
    .clk(clk), .rst(rst), .opc(opc), .mem_ack(mem_ack), .zero(zero), .neg(neg), .resume(resume),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .mdr_write(mdr_write),
    .pc_write(pc_write), .pc_src(pc_src), .acc_write(acc_write), .acc_src(acc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .rst_dp(rst_dp), .halted(halted),
    .illegal(illegal), .alu_op(alu_op)
  );
  assign got = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src, acc_write, acc_src,
                alu_src_a, alu_src_b, rst_dp, halted, illegal, alu_op};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask
  always @(negedge clk) if (exp_q.size() > 0) chk("cycle", 32'(got), 32'(exp_q.pop_front()));
  // instruction class: 0 two-operand ALU, 1 NOT, 2 load, 3 store, 4 control flow, 5 halt, 6 illegal
  function automatic int kind(input logic [3:0] op);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h8, 4'h9: return 0;
      4'h3: return 1;
      4'h4: return 2;
      4'h5: return 3;
      4'h6, 4'h7, 4'hA, 4'hB: return 4;
      4'hF: return 5;
      default: return 6;
    endcase
  endfunction
  function automatic vec_t ex_v(input logic [3:0] op);
    case (op)
      4'h1: return SRCA | 18'd1;
      4'h2: return SRCA | 18'd2;
      4'h3: return SRCA | 18'd3;
      4'h8: return SRCA | 18'd4;
      4'h9: return SRCA | 18'd5;
      default: return SRCA;
    endcase
  endfunction
  function automatic vec_t id_v(input logic [3:0] op, input logic z, input logic n);
    return op == 4'h6 ? PCW : op == 4'h7 ? (z ? PCW : 0) : op == 4'hA ? (n ? PCW : 0) : 0;
  endfunction
  task automatic adv();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic r, input logic ack, input logic res, input vec_t e);
    rst = r;
    mem_ack = ack;
    resume = res;
    exp_q.push_back(e);
  endtask
  task automatic step(input logic r, input logic ack, input logic res, input vec_t e);
    adv();
    drv(r, ack, res, e);
  endtask
  // runs one instruction from fetch to its last cycle; stray ack/resume are driven where they must be ignored
  task automatic instr(input logic [3:0] op, input int wif, input int wmem, input logic z, input logic n,
                       output int cyc);
    cyc = 0;
    for (int i = 0; i <= wif; i++) begin
      adv();
      if (i == 0) begin opc = op; zero = z; neg = n; end
      drv(0, i == wif, 1, MREQ | SRCB | PCSRC | (i == wif ? IRW | PCW : 0));
      cyc++;
    end
    step(0, 1, 1, id_v(op, z, n));
    cyc++;
    case (kind(op))
      0, 2: begin
        for (int i = 0; i <= wmem; i++) begin
          step(0, i == wmem, 1, MREQ | IORD |
               (i == wmem ? MDRW | (op == 4'h4 ? ACCW | ACCSRC : 0) : 0));
          cyc++;
        end
        if (op != 4'h4) begin
          step(0, 1, 1, ex_v(op));
          step(0, 1, 1, ACCW);
          cyc += 2;
        end
      end
      1: begin
        step(0, 1, 1, ex_v(op));
        step(0, 1, 1, ACCW);
        cyc += 2;
      end
      3: for (int i = 0; i <= wmem; i++) begin
        step(0, i == wmem, 1, MREQ | MWE | IORD);
        cyc++;
      end
      default: ;
    endcase
  endtask
  task automatic mid_rst(input string nm);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk(nm, 32'(got), 32'(RSTDP));
  endtask
  initial begin
    step(1, 0, 0, RSTDP);
    step(1, 0, 0, RSTDP);
    step(0, 0, 0, RSTDP);
    instr(4'h0, 0, 0, 0, 0, c); chk("cycles_add", c, 5);
    instr(4'h4, 0, 3, 0, 0, c); chk("cycles_lda_w3", c, 6);
    instr(4'h4, 0, 0, 0, 0, c); chk("cycles_lda", c, 3);
    instr(4'h7, 0, 0, 1, 0, c); chk("cycles_jz_taken", c, 2);
    instr(4'h7, 0, 0, 0, 1, c);
    instr(4'hA, 1, 0, 1, 1, c);
    instr(4'hA, 0, 0, 1, 0, c);
    instr(4'h6, 0, 0, 0, 0, c); chk("cycles_jmp", c, 2);
    instr(4'hB, 0, 0, 0, 0, c);
    instr(4'h1, 2, 1, 0, 0, c); chk("cycles_sub_w3", c, 8);
    instr(4'h2, 0, 0, 0, 0, c);
    instr(4'h8, 0, 2, 0, 0, c);
    instr(4'h9, 0, 0, 0, 0, c);
    instr(4'h3, 0, 0, 0, 0, c); chk("cycles_not", c, 4);
    instr(4'h5, 0, 0, 0, 0, c); chk("cycles_sta", c, 3);
    instr(4'h5, 0, 2, 0, 0, c); chk("cycles_sta_w2", c, 5);
    instr(4'hF, 0, 0, 0, 0, c);
    step(0, 1, 0, HALTV);
    step(0, 0, 1, HALTV);
    instr(4'h0, 0, 0, 0, 0, c);
    instr(4'hC, 0, 0, 0, 0, c);
    step(0, 0, 1, HALTV | ILL);
    step(0, 1, 1, HALTV | ILL);
    step(0, 0, 0, HALTV | ILL);
    mid_rst("rst_clears_illegal");
    step(0, 0, 0, RSTDP);
    instr(4'hE, 0, 0, 0, 0, c);
    step(0, 0, 1, HALTV | ILL);
    mid_rst("rst_clears_illegal_e");
    step(0, 0, 0, RSTDP);
    opc = 4'h5;
    step(0, 1, 0, MREQ | SRCB | PCSRC | IRW | PCW);
    step(0, 0, 0, 0);
    step(0, 0, 0, MREQ | MWE | IORD);
    mid_rst("rst_mid_store");
    step(0, 0, 0, RSTDP);
    instr(4'hB, 0, 0, 0, 0, c);
    adv();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
